// File: rtl/mlp_neuron_pkg.sv
// Shared types and fixed-point helpers for the MLP neuron slice.
// Build option: MAC_SATURATE_EN selects saturating accumulation.
package mlp_neuron_pkg;

    localparam int FRAC_BITS = 8;
    localparam int ONE       = 1 << FRAC_BITS;
    localparam int HALF      = ONE >> 1;

    typedef enum logic [1:0] {
        ACT_ID   = 2'd0,
        ACT_RELU = 2'd1,
        ACT_TANH = 2'd2,
        ACT_SIG  = 2'd3
    } act_mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_ACT,
        S_OUT
    } state_e;

    function automatic logic signed [63:0] sat_resize(
        input logic signed [63:0] v,
        input int unsigned        w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/neuron_act.sv
// Per-lane rescale and piecewise-linear activation.
// Purely combinational; the caller registers the result.
module neuron_act
    import mlp_neuron_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  act_mode_e                mode,
    output logic        [DATA_W-1:0] y
);

    localparam logic signed [63:0] ONE_V  = 64'sd1 <<< FRAC_W;
    localparam logic signed [63:0] HALF_V = 64'sd1 <<< (FRAC_W - 1);

    logic signed [63:0] x;
    logic signed [63:0] h;
    logic signed [DATA_W-1:0] r;

    always_comb begin
        x = 64'(acc >>> FRAC_W);
        h = (x >>> 2) + HALF_V;
        r = '0;
        unique case (1'b1)
            (mode == ACT_ID):
                r = DATA_W'(sat_resize(x, DATA_W));
            (mode == ACT_RELU):
                r = x[63] ? '0 : DATA_W'(sat_resize(x, DATA_W));
            (mode == ACT_TANH):
                r = (x > ONE_V)  ? DATA_W'(ONE_V)  :
                    (x < -ONE_V) ? DATA_W'(-ONE_V) :
                    DATA_W'(x);
            (mode == ACT_SIG):
                r = (h > ONE_V) ? DATA_W'(ONE_V) :
                    h[63]       ? '0             :
                    DATA_W'(h);
            default: r = '0;
        endcase
    end

    assign y = r;

endmodule

// File: rtl/mac_neuron_array.sv
// Parallel MAC neuron lanes sharing one streamed input vector.
// Build option: MAC_SATURATE_EN saturates accumulators and drives ovf.
module mac_neuron_array
    import mlp_neuron_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FRAC_W      = 8,
    parameter int ACC_W       = 40,
    parameter int NUM_NEURONS = 4,
    parameter int NUM_INPUTS  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ACC_W*NUM_NEURONS-1:0]  bias_flat,
    input  logic [1:0]                    act_mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [DATA_W*NUM_NEURONS-1:0] weights_flat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W*NUM_NEURONS-1:0] out_data,
    output logic [NUM_NEURONS-1:0]        ovf,
    output logic                          busy
);

    localparam int CNT_W = $clog2(NUM_INPUTS + 1);

    state_e           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             drain_q;
    logic             pv_q;
    act_mode_e        mode_q;
    logic             load, accept, act_en;

    assign load      = (state_q == S_IDLE) && start;
    assign in_ready  = (state_q == S_ACCUM) &&
                       (cnt_q < CNT_W'(NUM_INPUTS));
    assign accept    = in_valid && in_ready;
    assign act_en    = (state_q == S_ACT);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_nxt = S_ACCUM;
            S_ACCUM: if (accept &&
                         cnt_q == CNT_W'(NUM_INPUTS - 1))
                         state_nxt = S_DRAIN;
            S_DRAIN: if (drain_q) state_nxt = S_ACT;
            S_ACT:   state_nxt = S_OUT;
            S_OUT:   if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            pv_q    <= 1'b0;
            mode_q  <= ACT_ID;
        end else begin
            state_q <= state_nxt;
            pv_q    <= accept;
            drain_q <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;
            if (load) begin
                cnt_q  <= '0;
                mode_q <= act_mode_e'(act_mode);
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_lane
        logic        [DATA_W-1:0]   w_k;
        logic signed [2*DATA_W-1:0] prod_q;
        logic signed [ACC_W-1:0]    prod_x;
        logic signed [ACC_W-1:0]    acc_q;
        logic signed [ACC_W-1:0]    acc_nxt;
        logic        [DATA_W-1:0]   act_y;
        logic        [DATA_W-1:0]   res_q;

        assign w_k    = weights_flat[k*DATA_W +: DATA_W];
        assign prod_x = ACC_W'(prod_q);

`ifdef MAC_SATURATE_EN
        logic signed [ACC_W:0] sum;
        logic                  sum_ovf;
        logic                  ovf_q;

        assign sum     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_x);
        assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        // Sign of the wide sum picks which rail to clamp to.
        assign acc_nxt = !sum_ovf   ? sum[ACC_W-1:0] :
                         sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                ovf_q <= 1'b0;
            else if (load)             ovf_q <= 1'b0;
            else if (pv_q && sum_ovf)  ovf_q <= 1'b1;
        end

        assign ovf[k] = ovf_q;
`else
        assign acc_nxt = acc_q + prod_x;
        assign ovf[k]  = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod_q <= '0;
                acc_q  <= '0;
                res_q  <= '0;
            end else begin
                if (accept)
                    prod_q <= (2*DATA_W)'($signed(in_data)) *
                              (2*DATA_W)'($signed(w_k));
                if (load)
                    acc_q <= $signed(bias_flat[k*ACC_W +: ACC_W]);
                else if (pv_q)
                    acc_q <= acc_nxt;
                if (act_en)
                    res_q <= act_y;
            end
        end

        neuron_act #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .ACC_W  (ACC_W)
        ) u_act (
            .acc  (acc_q),
            .mode (mode_q),
            .y    (act_y)
        );

        assign out_data[k*DATA_W +: DATA_W] = res_q;
    end

endmodule

// File: tb/tb_mac_neuron_array.sv
// Directed bench for mac_neuron_array (ACC_W=32, NUM_INPUTS=4).
// Covers activations, flow control, overflow, reset abort, latency.
module tb_mac_neuron_array;
    import mlp_neuron_pkg::*;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int NN = 4;
    localparam int NI = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW*NN-1:0] bias_flat = '0;
    logic [1:0]      act_mode = 2'd0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic [DW*NN-1:0] weights_flat = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW*NN-1:0] out_data;
    logic [NN-1:0]   ovf;
    logic            busy;

    int n_chk = 0;
    int n_err = 0;

    mac_neuron_array #(
        .DATA_W      (DW),
        .FRAC_W      (FRAC_BITS),
        .ACC_W       (AW),
        .NUM_NEURONS (NN),
        .NUM_INPUTS  (NI)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bias_flat    (bias_flat),
        .act_mode     (act_mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .weights_flat (weights_flat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .ovf          (ovf),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"},  64'(in_ready),  64'd0);
        chk({tag, "_ov"},   64'(out_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy),      64'd0);
    endtask

    // Starts a vector and feeds NI beats of (din, w); bubbles carry junk.
    task automatic feed(input logic [AW*NN-1:0] bias,
                        input logic [1:0] mode,
                        input logic [DW-1:0] din,
                        input logic [DW*NN-1:0] w,
                        input bit stall,
                        input int nbeats,
                        input string tag);
        int beats;
        int cyc;
        logic rdy;
        @(negedge clk);
        start = 1'b1;
        bias_flat = bias;
        act_mode = mode;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_rdy1"}, 64'(in_ready), 64'd1);
        // Later changes must not affect the running vector.
        bias_flat = {NN{32'h1234_5678}};
        act_mode = ~mode;
        beats = 0;
        cyc = 0;
        while (beats < nbeats && cyc < 100) begin
            in_valid = !stall || (cyc % 2 == 0);
            in_data = in_valid ? din : 16'h7fff;
            weights_flat = in_valid ? w : {NN{16'h7fff}};
            rdy = in_ready;
            @(negedge clk);
            if (in_valid && rdy) beats++;
            cyc++;
        end
        in_valid = 1'b0;
        in_data = 16'h7fff;
        weights_flat = {NN{16'h7fff}};
        if (beats < nbeats)
            chk({tag, "_beats"}, 64'(beats), 64'(nbeats));
    endtask

    task automatic run_vec(input logic [AW*NN-1:0] bias,
                           input logic [1:0] mode,
                           input logic [DW-1:0] din,
                           input logic [DW*NN-1:0] w,
                           input bit stall,
                           input bit hold,
                           input logic [DW*NN-1:0] exp_d,
                           input logic [NN-1:0] exp_ovf,
                           input string tag);
        int lat;
        logic [DW*NN-1:0] snap;
        feed(bias, mode, din, w, stall, NI, tag);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd3);
        for (int k = 0; k < NN; k++)
            chk($sformatf("%s_l%0d", tag, k),
                64'(out_data[k*DW +: DW]),
                64'(exp_d[k*DW +: DW]));
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        if (hold) begin
            snap = out_data;
            for (int i = 0; i < 10; i++) begin
                start = 1'b1;
                @(negedge clk);
                chk($sformatf("%s_hv%0d", tag, i),
                    64'(out_valid), 64'd1);
                chk($sformatf("%s_hd%0d", tag, i),
                    64'(out_data), 64'(snap));
            end
        end
        // Handshake with start raised in the same cycle.
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        chk({tag, "_done_ov"}, 64'(out_valid), 64'd0);
        chk({tag, "_done_busy"}, 64'(busy), 64'd0);
    endtask

    localparam logic [DW*NN-1:0] W_STD =
        {16'hffc0, 16'h0020, 16'hff00, 16'h0100};
    localparam logic [DW-1:0] D_ONE = 16'(ONE);
    localparam logic [AW*NN-1:0] B_ZERO = '0;
    localparam logic [AW*NN-1:0] B_M3 =
        {32'h0, 32'h0, 32'h0, 32'hfffd_0000};

    initial begin
        repeat (3) @(negedge clk);
        chk_idle("rst0");
        chk("rst0_data", 64'(out_data), 64'd0);
        chk("rst0_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec(B_ZERO, 2'd0, D_ONE, W_STD, 1'b0, 1'b0,
                {16'hff00, 16'h0080, 16'hfc00, 16'h0400},
                4'h0, "id");
        run_vec(B_ZERO, 2'd1, D_ONE, W_STD, 1'b0, 1'b0,
                {16'h0000, 16'h0080, 16'h0000, 16'h0400},
                4'h0, "relu");
        run_vec(B_ZERO, 2'd2, D_ONE, W_STD, 1'b0, 1'b0,
                {16'hff00, 16'h0080, 16'hff00, 16'h0100},
                4'h0, "tanh");
        run_vec(B_ZERO, 2'd3, D_ONE, W_STD, 1'b0, 1'b0,
                {16'h0040, 16'h00a0, 16'h0000, 16'h0100},
                4'h0, "sig");
        run_vec(B_M3, 2'd3, D_ONE, W_STD, 1'b0, 1'b0,
                {16'h0040, 16'h00a0, 16'h0000, 16'h00c0},
                4'h0, "sigb");
        run_vec(B_ZERO, 2'd0, D_ONE, W_STD, 1'b1, 1'b1,
                {16'hff00, 16'h0080, 16'hfc00, 16'h0400},
                4'h0, "stall");

`ifdef MAC_SATURATE_EN
        run_vec(B_ZERO, 2'd0, 16'h8000, {NN{16'h8000}},
                1'b0, 1'b0, {NN{16'h7fff}}, 4'hf, "ovfl");
`else
        run_vec(B_ZERO, 2'd0, 16'h8000, {NN{16'h8000}},
                1'b0, 1'b0, {NN{16'h0000}}, 4'h0, "ovfl");
`endif

        // Abort a vector after two beats.
        feed(B_M3, 2'd3, 16'h0300, {NN{16'h0500}},
             1'b0, 2, "abort");
        rst_n = 1'b0;
        #1;
        chk_idle("rstm");
        chk("rstm_data", 64'(out_data), 64'd0);
        chk("rstm_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_idle("rsts");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("rstr");

        run_vec(B_ZERO, 2'd0, D_ONE, W_STD, 1'b0, 1'b0,
                {16'hff00, 16'h0080, 16'hfc00, 16'h0400},
                4'h0, "post");

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mac_neuron_array.md
# mac_neuron_array

- Layer-slice engine for the MLP datapath.
- `NUM_NEURONS` neurons share one streamed input vector, each with its own per-beat weight and bias.
- Each neuron has an inferred two-stage multiply-accumulate pipeline and a selectable piecewise-linear activation.
- The block replaces one-neuron-at-a-time MAC/CORDIC sequencing. It emits one packed result vector per `start` through a valid/ready output.

## Interface
- `DATA_W`, 16: input, weight and output width; signed fixed point with `FRAC_W` fraction bits.
- `FRAC_W`, 8: fraction bits of data/weights. Products and bias carry 2·`FRAC_W` fraction bits.
- `ACC_W`, 40: accumulator width; ≥ 2·`DATA_W`.
- `NUM_NEURONS`, 4: parallel neurons (lanes).
- `NUM_INPUTS`, 8: beats per vector, ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a vector; honoured only in IDLE. Samples `bias_flat` and `act_mode`.
- `bias_flat` in `ACC_W*NUM_NEURONS`: per-lane bias; lane k is at `[k*ACC_W +: ACC_W]`.
- `act_mode` in 2: 0 identity, 1 ReLU, 2 hard-tanh, 3 hard-sigmoid.
- `in_valid` in 1, `in_ready` out 1: input beat handshake.
- `in_data` in `DATA_W`: shared input element for this beat.
- `weights_flat` in `DATA_W*NUM_NEURONS`: lane-k weight for this beat.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_data` out `DATA_W*NUM_NEURONS`: packed activated results.
- `ovf` out `NUM_NEURONS`: per-lane accumulator overflow seen during this vector.
- `busy` out 1: state ≠ IDLE.

## Operation
States and transitions:
- IDLE → ACCUM on `start`. Accumulators load the bias; beat counter clears.
- ACCUM: `in_ready` = 1 while beat count < `NUM_INPUTS`. After the `NUM_INPUTS`-th accepted beat → DRAIN.
- DRAIN: two cycles, until the product and accumulate stages are empty → ACT.
- ACT: one cycle; registers the activated results → OUT.
- OUT: holds `out_valid` and `out_data` stable until `out_ready` → IDLE.

Pipeline and arithmetic:
- Stage 1 registers the product `in_data*weight` (2·`DATA_W` bits, sign-extended to `ACC_W`).
- Stage 2 adds the product into the accumulator.
- Activation input: x = acc >>> `FRAC_W` (arithmetic shift).
- Identity: x saturated to the `DATA_W` range.
- ReLU: max(x, 0), then saturated.
- Hard-tanh: clamp x to ±(1<<`FRAC_W`).
- Hard-sigmoid: clamp((x>>>2) + (1<<(`FRAC_W`-1)), 0, 1<<`FRAC_W`).
- `ovf[k]` is sticky from `start` until the next `start`.

Boundary conditions:
- `in_valid` low stalls accumulation; bubbles never add.
- `start` outside IDLE is ignored, including in the cycle OUT completes.
- `start` is ignored while `rst_n` is low.
- `act_mode` and `bias_flat` changes after `start` have no effect on the current vector.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `ovf`=0, `busy`=0; state IDLE; accumulators and pipeline cleared.
- Reset mid-operation aborts the vector with no output.
- `start` at edge S: `in_ready`=1 from the cycle after S.
- Last beat accepted at edge T: product at T+1, accumulate at T+2, activation registered at T+3. `out_valid`=1 in the cycle after T+3.
- Minimum vector period: 1 + `NUM_INPUTS` + 4 cycles with `out_ready` held high.
- `out_ready` high at edge U with `out_valid` high: transfer completes; `out_valid`=0 and `busy`=0 after U.

## Configuration
- `MAC_SATURATE_EN` defined: each accumulate saturates at the signed `ACC_W` bounds and sets `ovf[k]`.
- Undefined: the accumulator wraps modulo 2^`ACC_W` and `ovf` is tied to 0.

## Structure
- Package `mlp_neuron_pkg` holds:
  - `act_mode` localparams or enum;
  - the state enum;
  - the fixed-point constants ONE = 1<<`FRAC_W` and HALF;
  - a saturating-resize function.
- Sub-module `neuron_act`: per-lane combinational shift/activation/saturate. It is instantiated `NUM_NEURONS` times in a generate loop; ACT registers its output.

## Test plan
Defaults unless stated; 1.0 = 256.
- Identity: `NUM_INPUTS`=4, all inputs 256, lane-0 weight 256, bias 0, mode 0 → lane 0 = 1024. Lane with weight −256, mode 1 → 0.
- Hard-tanh and hard-sigmoid: same vector as above, mode 2 → 256; mode 3 → 256. Bias −196608 (−3.0 at 2·`FRAC_W`), mode 3 → lane 0 = 192.
- Flow control:
  - `in_valid` toggles every other cycle → identical results to back-to-back.
  - `out_ready` held low 10 cycles → `out_data` stable and `start` ignored.
- Overflow: `ACC_W`=32, `NUM_INPUTS`=4, inputs and weights −32768.
  - With `MAC_SATURATE_EN`: acc = 2^31−1, `ovf[0]`=1.
  - Without: acc wraps to 0, `ovf`=0.
- Reset: assert `rst_n` low after 2 beats → all outputs at reset values. Next vector after release → correct result, no residue from the aborted vector.
- Timing: last beat accepted at edge T → `out_valid` first high after edge T+3. `start` in the same cycle as the OUT handshake → ignored.
